// File: rtl/divider_scheduler_if.sv
// Request/response bundle between NUM_REQ requesters and the divider scheduler.
// Member names follow the scheduler's original port names.
interface divider_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_dividend;
  logic [NUM_REQ*16-1:0] req_divisor;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_quotient;
  logic [15:0]           rsp_remainder;
  logic                  rsp_err;

  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_err
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_err
  );
endinterface

// File: rtl/divider_scheduler.sv
// Round-robin scheduler sharing one restoring 32/16 divider among NUM_REQ requesters;
// results return on a single response channel tagged with the requester id.
module divider_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  divider_scheduler_if.slave  bus,
  output logic [31:0]         div_dividend,
  output logic [15:0]         div_divisor,
  output logic                div_init,
  input  logic [31:0]         div_quotient,
  input  logic [15:0]         div_remainder,
  output logic                busy
);

  localparam int unsigned CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CAPT,
    S_RESP
  } state_t;

  state_t           state_q;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      dividend_q;
  logic [15:0]      divisor_q;
  logic             div_init_q;
  logic             busy_q;
  logic             rsp_valid_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [31:0]      rsp_quot_q;
  logic [15:0]      rsp_rem_q;
  logic             rsp_err_q;

  logic [31:0] dvd_arr [NUM_REQ];
  logic [15:0] dvs_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign dvd_arr[g] = bus.req_dividend[32*g +: 32];
    assign dvs_arr[g] = bus.req_divisor[16*g +: 16];
  end

  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand_id;
  logic [31:0]     sel_dvd;
  logic [15:0]     sel_dvs;

  // First valid requester found walking forward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_id   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_id = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_vld && bus.req_valid[cand_id]) begin
        grant_vld = 1'b1;
        grant_idx = cand_id;
      end
    end
  end

  assign sel_dvd = dvd_arr[grant_idx];
  assign sel_dvs = dvs_arr[grant_idx];

  always_comb begin
    bus.req_ready = '0;
    if (reset_n && (state_q == S_IDLE) && grant_vld) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      div_init_q  <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_quot_q  <= '0;
      rsp_rem_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            dividend_q <= sel_dvd;
            divisor_q  <= sel_dvs;
            rsp_id_q   <= grant_idx;
            rr_ptr_q   <= (grant_idx == ID_LAST) ? '0 : grant_idx + 1'b1;
            busy_q     <= 1'b1;
            if (sel_dvs == '0) begin
              // Divide-by-zero answers directly; the divider is never initialised.
              rsp_quot_q  <= '1;
              rsp_rem_q   <= '0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              div_init_q <= 1'b1;
              state_q    <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          div_init_q <= 1'b0;
          cnt_q      <= '0;
          state_q    <= S_RUN;
        end
        S_RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= S_CAPT;
          end
        end
        S_CAPT: begin
          rsp_quot_q  <= div_quotient;
          rsp_rem_q   <= div_remainder;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign div_dividend      = dividend_q;
  assign div_divisor       = divisor_q;
  assign div_init          = div_init_q;
  assign busy              = busy_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_quotient  = rsp_quot_q;
  assign bus.rsp_remainder = rsp_rem_q;
  assign bus.rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_divider_scheduler.sv
// Directed bench for divider_scheduler with a behavioural restoring divider attached.
module tb_divider_scheduler;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned ID_W       = 2;
  localparam int unsigned DIV_CYCLES = 32;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] div_dividend;
  logic [15:0] div_divisor;
  logic        div_init;
  logic [31:0] div_quotient;
  logic [15:0] div_remainder;
  logic        busy;

  int n_vec  = 0;
  int n_bad  = 0;
  int n_init = 0;

  divider_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  divider_scheduler #(
    .NUM_REQ   (NUM_REQ),
    .ID_W      (ID_W),
    .DIV_CYCLES(DIV_CYCLES)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .bus          (bus),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_init     (div_init),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  // Restoring divider: init loads the dividend, then one quotient bit per clock for 32 clocks.
  logic [31:0] m_q = '0;
  logic [15:0] m_r = '0;
  int unsigned m_steps = 32;

  always @(posedge clock) begin
    if (div_init === 1'b1) begin
      m_q     <= div_dividend;
      m_r     <= '0;
      m_steps <= 0;
      n_init  <= n_init + 1;
    end else if (m_steps < 32) begin
      logic [16:0] t;
      t = {m_r, m_q[31]};
      if (t >= {1'b0, div_divisor}) begin
        m_r <= 16'(t - {1'b0, div_divisor});
        m_q <= {m_q[30:0], 1'b1};
      end else begin
        m_r <= t[15:0];
        m_q <= {m_q[30:0], 1'b0};
      end
      m_steps <= m_steps + 1;
    end
  end

  assign div_quotient  = m_q;
  assign div_remainder = m_r;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int unsigned i, input logic [31:0] dvd, input logic [15:0] dvs);
    bus.req_dividend[32*i +: 32] = dvd;
    bus.req_divisor[16*i +: 16]  = dvs;
    bus.req_valid[i]             = 1'b1;
  endtask

  // Wait for a grant, check it targets id, and drop the granted valid after the accept edge.
  task automatic accept(input int unsigned id);
    logic [NUM_REQ-1:0] g;
    logic [NUM_REQ-1:0] oh;
    int unsigned t;
    t  = 0;
    oh = '0;
    oh[id] = 1'b1;
    @(negedge clock);
    while (bus.req_ready == '0 && t < 200) begin
      @(negedge clock);
      t++;
    end
    g = bus.req_ready;
    chk($sformatf("grant%0d", id), 64'(g), 64'(oh));
    @(posedge clock);
    #1;
    bus.req_valid = bus.req_valid & ~g;
    chk("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic serve(input int unsigned id, input logic [31:0] q, input logic [15:0] r,
                       input logic err, input int unsigned lat, input int unsigned hold);
    int unsigned t;
    accept(id);
    t = 0;
    while (bus.rsp_valid !== 1'b1 && t < 200) begin
      @(posedge clock);
      #1;
      t++;
    end
    chk("latency", 64'(t), 64'(lat));
    chk("rsp_id", 64'(bus.rsp_id), 64'(id));
    chk("rsp_q", 64'(bus.rsp_quotient), 64'(q));
    chk("rsp_r", 64'(bus.rsp_remainder), 64'(r));
    chk("rsp_err", 64'(bus.rsp_err), 64'(err));
    chk("ready_in_resp", 64'(bus.req_ready), 64'd0);
    for (int unsigned c = 0; c < hold; c++) begin
      @(posedge clock);
      #1;
      chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("hold_id", 64'(bus.rsp_id), 64'(id));
      chk("hold_q", 64'(bus.rsp_quotient), 64'(q));
      chk("hold_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.rsp_ready = 1'b0;
    chk("busy_after_rsp", 64'(busy), 64'd0);
    chk("valid_after_rsp", 64'(bus.rsp_valid), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_rsp_fields"},
        {11'd0, bus.rsp_err, bus.rsp_id, bus.rsp_remainder, bus.rsp_quotient}, 64'd0);
    chk({tag, "_div"}, {15'd0, div_init, div_divisor, div_dividend}, 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int init_snap;
    bus.req_valid    = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.rsp_ready    = 1'b0;

    // Reset with all four requesters already waiting.
    set_req(0, 32'd1000, 16'd10);
    set_req(1, 32'd12345, 16'd100);
    set_req(2, 32'd7, 16'd2);
    set_req(3, 32'd65536, 16'd3);
    repeat (3) @(posedge clock);
    #1;
    chk_reset_outputs("reset");
    reset_n = 1'b1;

    serve(0, 32'd100, 16'd0, 1'b0, 34, 0);
    serve(1, 32'd123, 16'd45, 1'b0, 34, 0);
    serve(2, 32'd3, 16'd1, 1'b0, 34, 0);
    serve(3, 32'd21845, 16'd1, 1'b0, 34, 0);

    set_req(1, 32'd50, 16'd6);
    set_req(3, 32'd1000000, 16'd1000);
    serve(1, 32'd8, 16'd2, 1'b0, 34, 0);
    serve(3, 32'd1000, 16'd0, 1'b0, 34, 0);

    set_req(0, 32'd100, 16'd7);
    serve(0, 32'd14, 16'd2, 1'b0, 34, 0);

    init_snap = n_init;
    set_req(2, 32'd55, 16'd0);
    serve(2, 32'hFFFF_FFFF, 16'd0, 1'b1, 0, 0);
    chk("div0_no_init", 64'(n_init - init_snap), 64'd0);
    chk("div0_divisor", 64'(div_divisor), 64'd0);

    set_req(3, 32'd1000, 16'd7);
    set_req(0, 32'd5, 16'd9);
    serve(3, 32'd142, 16'd6, 1'b0, 34, 10);
    chk("grant_after_release", 64'(bus.req_ready), 64'b0001);
    serve(0, 32'd0, 16'd5, 1'b0, 34, 0);

    set_req(1, 32'hFFFF_FFFF, 16'hFFFF);
    serve(1, 32'h0001_0001, 16'd0, 1'b0, 34, 0);
    set_req(2, 32'hFFFF_FFFF, 16'd1);
    serve(2, 32'hFFFF_FFFF, 16'd0, 1'b0, 34, 0);

    // Reset while the divider is at RUN cnt=10; the job must vanish.
    set_req(3, 32'd100, 16'd7);
    accept(3);
    set_req(0, 32'd999, 16'd4);
    repeat (11) @(posedge clock);
    #1;
    chk("run_busy", 64'(busy), 64'd1);
    chk("run_init_low", 64'(div_init), 64'd0);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midjob");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    serve(0, 32'd249, 16'd3, 1'b0, 34, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
